// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the MIPS datapath (slave).
// The master consumes IR fields and datapath status and drives every select and strobe.
interface multicycle_control_fsm_if #(
  parameter int OPW   = 4,
  parameter int FNW   = 3,
  parameter int ALUCW = 4
);
  logic [OPW-1:0]   opcode;
  logic [FNW-1:0]   funct;
  logic             zero;
  logic             mem_ready;
  logic             pc_en;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_source;
  logic [ALUCW-1:0] alu_control;
  logic             illegal_op;
  logic [3:0]       state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_source, alu_control, illegal_op, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_source, alu_control, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-16 control unit: sequences FETCH..WRITEBACK, Moore outputs registered from next state.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; rst forces every strobe and select low immediately.
module multicycle_control_fsm #(
  parameter int OPW   = 4,
  parameter int FNW   = 3,
  parameter int ALUCW = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_e;

  localparam logic [OPW-1:0] OP_R    = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_J    = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(4'b0100);
  localparam logic [OPW-1:0] OP_LW   = OPW'(4'b0101);
  localparam logic [OPW-1:0] OP_SW   = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(4'b0111);

  localparam logic [ALUCW-1:0] ALU_AND = ALUCW'(4'b0000);
  localparam logic [ALUCW-1:0] ALU_OR  = ALUCW'(4'b0001);
  localparam logic [ALUCW-1:0] ALU_ADD = ALUCW'(4'b0010);
  localparam logic [ALUCW-1:0] ALU_SUB = ALUCW'(4'b0110);
  localparam logic [ALUCW-1:0] ALU_SLT = ALUCW'(4'b0111);
  localparam logic [ALUCW-1:0] ALU_NOR = ALUCW'(4'b1100);

  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_write_rdy;
    logic             pc_write;
    logic             pc_write_cond;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [ALUCW-1:0] alu_control;
    logic             is_decode;
    logic             is_exec;
  } ctrl_t;

  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic             op_legal;
  logic             fn_legal;
  logic [ALUCW-1:0] fn_alu;

  function automatic ctrl_t ctrl_for(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_control = ALU_ADD;
        c.ir_write = 1'b1; c.pc_write_rdy = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b10; c.alu_control = ALU_ADD; c.is_decode = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = ALU_ADD;
      end
      S_MEMRD:  begin c.mem_read = 1'b1;  c.iord = 1'b1; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.is_exec = 1'b1; end
      S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_ADDIWB: c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_control = ALU_SUB;
        c.pc_source = 2'b01; c.pc_write_cond = 1'b1;
      end
      S_JUMP:   begin c.pc_source = 2'b10; c.pc_write = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    op_legal = 1'b0;
    case (bus.opcode)
      OP_R, OP_J, OP_ADDI, OP_LW, OP_SW, OP_BEQ: op_legal = 1'b1;
      default:                                   op_legal = 1'b0;
    endcase
  end

  always_comb begin
    fn_legal = 1'b1;
    fn_alu   = ALU_AND;
    case (bus.funct)
      FNW'(3'd0): fn_alu = ALU_ADD;
      FNW'(3'd1): fn_alu = ALU_SUB;
      FNW'(3'd2): fn_alu = ALU_AND;
      FNW'(3'd3): fn_alu = ALU_OR;
      FNW'(3'd4): fn_alu = ALU_NOR;
      FNW'(3'd5): fn_alu = ALU_SLT;
      default:    fn_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = fn_legal ? S_ALUWB : S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output flags are loaded with the decode of the state being entered, so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d);
    end
  end

  assign bus.mem_read    = ~rst & ctrl_q.mem_read;
  assign bus.mem_write   = ~rst & ctrl_q.mem_write;
  assign bus.iord        = ~rst & ctrl_q.iord;
  assign bus.ir_write    = ~rst & ctrl_q.ir_write & bus.mem_ready;
  assign bus.pc_en       = ~rst & ((ctrl_q.pc_write_rdy & bus.mem_ready) | ctrl_q.pc_write |
                                   (ctrl_q.pc_write_cond & bus.zero));
  assign bus.reg_dst     = ~rst & ctrl_q.reg_dst;
  assign bus.mem_to_reg  = ~rst & ctrl_q.mem_to_reg;
  assign bus.reg_write   = ~rst & ctrl_q.reg_write;
  assign bus.alu_src_a   = ~rst & ctrl_q.alu_src_a;
  assign bus.alu_src_b   = rst ? 2'b00 : ctrl_q.alu_src_b;
  assign bus.pc_source   = rst ? 2'b00 : ctrl_q.pc_source;
  // EXEC takes its ALU op from the IR funct field; an illegal funct leaves fn_alu at AND (0000).
  assign bus.alu_control = rst ? '0 : (ctrl_q.is_exec ? fn_alu : ctrl_q.alu_control);
  assign bus.illegal_op  = ~rst & ((ctrl_q.is_decode & ~op_legal) | (ctrl_q.is_exec & ~fn_legal));
  assign bus.state       = state_q;

endmodule
